// File: rtl/bitwise_pkg.sv
// Definitions shared by the bitwise unit and its issuer: opcode class codes,
// instruction word width and issuer FSM state encoding.
package bitwise_pkg;

  localparam int unsigned INSTR_W = 12;

  // Class codes carried in op[3:2]; op[1:0] selects a register.
  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ASL = 2'b10;
  localparam logic [1:0] OP_SWP = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StAck   = 3'd2,
    StRun   = 3'd3,
    StFin   = 3'd4
  } issuer_state_e;

endpackage

// File: rtl/bitwise_prog_mem.sv
// Program store for the issuer: DEPTH x INSTR_W registers with one
// synchronous write port and one asynchronous read port. Not reset.
module bitwise_prog_mem
  import bitwise_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bitwise_issuer.sv
// Issues a stored {op,imm} program to the bitwise unit over its s/op/in/done
// handshake. Optional done-wait timeout enabled by defining ISSUER_TIMEOUT_EN.
module bitwise_issuer
  import bitwise_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [AW:0]        len,
  input  logic               start,
  output logic               s,
  output logic [3:0]         op,
  output logic [7:0]         in,
  input  logic               done_in,
  input  logic [7:0]         result_in,
  output logic [7:0]         result,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               finished,
  output logic               error
);

  issuer_state_e      r_state;
  logic               r_s;
  logic [3:0]         r_op;
  logic [7:0]         r_in;
  logic [7:0]         r_result;
  logic [AW-1:0]      r_pc;
  logic [AW:0]        r_len;
  logic               r_busy;
  logic               r_fin;

  logic [AW-1:0]      w_raddr;
  logic [INSTR_W-1:0] w_rdata;
  logic               w_last;
  logic               w_tmo_hit;

  // Fetch is combinational so op/in can be loaded on the same edge that enters ISSUE.
  assign w_raddr = (r_state == StRun) ? r_pc + AW'(1) : '0;
  assign w_last  = ({1'b0, r_pc} == r_len - (AW + 1)'(1));

  bitwise_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (prog_we && (r_state == StIdle)),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_s      <= 1'b0;
      r_op     <= '0;
      r_in     <= '0;
      r_result <= '0;
      r_pc     <= '0;
      r_len    <= '0;
      r_busy   <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_s   <= 1'b0;
      r_fin <= 1'b0;
      if (w_tmo_hit) begin
        r_state <= StFin;
        r_fin   <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (start && (len == '0)) begin
              r_state <= StFin;
              r_busy  <= 1'b1;
              r_fin   <= 1'b1;
            end else if (start && done_in) begin
              r_state       <= StIssue;
              r_busy        <= 1'b1;
              r_s           <= 1'b1;
              r_pc          <= '0;
              r_len         <= len;
              {r_op, r_in}  <= w_rdata;
            end
          end
          StIssue: r_state <= StAck;
          StAck: begin
            if (!done_in) r_state <= StRun;
          end
          StRun: begin
            if (done_in) begin
              r_result <= result_in;
              if (w_last) begin
                r_state <= StFin;
                r_fin   <= 1'b1;
              end else begin
                r_state      <= StIssue;
                r_s          <= 1'b1;
                r_pc         <= r_pc + AW'(1);
                {r_op, r_in} <= w_rdata;
              end
            end
          end
          StFin: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef ISSUER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo;
  logic          r_err;

  assign w_tmo_hit = ((r_state == StAck) || (r_state == StRun)) &&
                     (r_tmo == TW'(TIMEOUT - 1));

  // Restart the count when ACK hands over to RUN so each phase gets a full budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_tmo_hit) r_err <= 1'b1;
      if ((r_state == StAck) && !done_in) begin
        r_tmo <= '0;
      end else if ((r_state == StAck) || (r_state == StRun)) begin
        r_tmo <= r_tmo + TW'(1);
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign error = r_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_tmo_hit        = 1'b0;
  assign error            = 1'b0;
`endif

  assign s        = r_s;
  assign op       = r_op;
  assign in       = r_in;
  assign result   = r_result;
  assign pc       = r_pc;
  assign busy     = r_busy;
  assign finished = r_fin;

endmodule

// File: tb/tb_bitwise_issuer.sv
// Bench for bitwise_issuer paired with a behavioural bitwise unit; the timeout
// scenario is exercised only when ISSUER_TIMEOUT_EN is defined.
module tb_bitwise_issuer;
  import bitwise_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  len;
  logic        start;
  logic        s;
  logic [3:0]  op;
  logic [7:0]  in_b;
  logic        done_in;
  logic [7:0]  result_in;
  logic [7:0]  result;
  logic [2:0]  pc;
  logic        busy;
  logic        finished;
  logic        error;

  bitwise_issuer #(
    .DEPTH   (8),
    .AW      (3),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .len       (len),
    .start     (start),
    .s         (s),
    .op        (op),
    .in        (in_b),
    .done_in   (done_in),
    .result_in (result_in),
    .result    (result),
    .pc        (pc),
    .busy      (busy),
    .finished  (finished),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Bitwise unit: busy MOV 1, XOR 3, ASL 4, SWP 3 cycles; reads op/in when it executes.
  logic [7:0] u_r [4];
  logic       u_done;
  int         u_cnt;
  logic       force_done1;

  function automatic int busy_of(input logic [1:0] c);
    case (c)
      OP_MOV:  return 1;
      OP_XOR:  return 3;
      OP_ASL:  return 4;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_done <= 1'b1;
      u_cnt  <= 0;
      for (int i = 0; i < 4; i++) u_r[i] <= 8'h00;
    end else if (u_done) begin
      if (s) begin
        u_done <= 1'b0;
        u_cnt  <= busy_of(op[3:2]);
      end
    end else if (u_cnt == 1) begin
      u_done <= 1'b1;
      case (op[3:2])
        OP_MOV: u_r[op[1:0]] <= in_b;
        OP_XOR: u_r[0] <= u_r[1] ^ u_r[2];
        OP_ASL: u_r[0] <= {u_r[1][6:0] & u_r[2][6:0], 1'b0};
        default: begin
          u_r[0]     <= u_r[op[1:0]];
          u_r[op[1:0]] <= u_r[0];
        end
      endcase
    end else begin
      u_cnt <= u_cnt - 1;
    end
  end

  assign done_in   = u_done | force_done1;
  assign result_in = u_r[0];

  // Observers sampled on the falling edge.
  int         cyc = 0;
  int         s_cnt = 0;
  int         stab_err = 0;
  int         fin_cnt = 0;
  logic [3:0] prev_op;
  logic [7:0] prev_in;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s) s_cnt <= s_cnt + 1;
    else if ((op !== prev_op) || (in_b !== prev_in)) stab_err <= stab_err + 1;
    prev_op <= op;
    prev_in <= in_b;
    if (finished) fin_cnt <= fin_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: architectural effect and cycle cost of a program, one instruction at a time.
  logic [7:0] m_r [4];
  logic [7:0] m_res;

  task automatic model_run(input logic [95:0] w, input int n, output int cycles);
    logic [11:0] iw;
    logic [7:0]  tmp;
    int          k;
    cycles = 2;  // start cycle plus the finished cycle
    for (int i = 0; i < n; i++) begin
      iw = w[i*12 +: 12];
      k  = int'(iw[9:8]);
      case (iw[11:10])
        OP_MOV: begin m_r[k] = iw[7:0]; cycles += 3; end
        OP_XOR: begin m_r[0] = m_r[1] ^ m_r[2]; cycles += 5; end
        OP_ASL: begin m_r[0] = {m_r[1][6:0] & m_r[2][6:0], 1'b0}; cycles += 6; end
        default: begin tmp = m_r[0]; m_r[0] = m_r[k]; m_r[k] = tmp; cycles += 5; end
      endcase
      m_res = m_r[0];
    end
  endtask

  task automatic prog_write(input logic [95:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = i[2:0];
      prog_data = w[i*12 +: 12];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Cycles are counted inclusively from the cycle start is high to the finished cycle.
  task automatic run_prog(input logic [95:0] w, input int n, input bit do_prog, input bit poke,
                          input string tag, input logic [7:0] exp_res, input int exp_cyc,
                          input int exp_s);
    int c0, cf, s0, e0, f0;
    bit seen;
    if (do_prog) prog_write(w);
    @(negedge clk);
    start = 1'b1;
    len   = n[3:0];
    c0    = cyc;
    #1;
    s0 = s_cnt; e0 = stab_err; f0 = fin_cnt;
    seen = 1'b0;
    cf   = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (finished) begin
        seen = 1'b1; cf = cyc; start = 1'b0; prog_we = 1'b0;
      end else if (poke) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 3'd2; prog_data = 12'h000;
      end else begin
        start = 1'b0;
      end
    end
    start   = 1'b0;
    prog_we = 1'b0;
    chk({tag, ".finished_seen"}, 32'(seen), 1);
    chk({tag, ".cycles"}, cf - c0 + 1, exp_cyc);
    chk({tag, ".result"}, 32'(result), 32'(exp_res));
    chk({tag, ".error"}, 32'(error), 32'(exp_err));
    if (n > 0) chk({tag, ".pc"}, 32'(pc), n - 1);
    @(negedge clk);
    chk({tag, ".finished_one_cycle"}, 32'(finished), 0);
    chk({tag, ".busy_after"}, 32'(busy), 0);
    #1;
    chk({tag, ".s_pulses"}, s_cnt - s0, exp_s);
    chk({tag, ".op_in_stable"}, stab_err - e0, 0);
    chk({tag, ".finished_count"}, fin_cnt - f0, 1);
  endtask

  function automatic logic [95:0] p3(input logic [11:0] a, input logic [11:0] b,
                                     input logic [11:0] c);
    return {60'd0, c, b, a};
  endfunction

  typedef struct {
    logic [95:0] w;
    int          n;
    logic [7:0]  res;
    int          cyc;
    int          ns;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int mc, nseen;
    logic [95:0] rw;
    int rn;

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    len = '0; start = 1'b0; force_done1 = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_res = 8'h00;

    tbl[0] = '{w: p3(12'h10F, 12'h23C, 12'h400), n: 3, res: 8'h33, cyc: 13, ns: 3};
    tbl[1] = '{w: p3(12'h10F, 12'h23C, 12'h800), n: 3, res: 8'h18, cyc: 14, ns: 3};
    tbl[2] = '{w: p3(12'h0AA, 12'h355, 12'hF00), n: 3, res: 8'h55, cyc: 13, ns: 3};
    tbl[3] = '{w: p3(12'h400, 12'h000, 12'h000), n: 1, res: 8'h33, cyc: 7,  ns: 1};

    repeat (2) @(negedge clk);
    chk("reset.s", 32'(s), 0);
    chk("reset.op", 32'(op), 0);
    chk("reset.in", 32'(in_b), 0);
    chk("reset.result", 32'(result), 0);
    chk("reset.pc", 32'(pc), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.finished", 32'(finished), 0);
    chk("reset.error", 32'(error), 0);
    reset = 1'b0;

    for (int t = 0; t < 4; t++) begin
      model_run(tbl[t].w, tbl[t].n, mc);
      run_prog(tbl[t].w, tbl[t].n, 1'b1, 1'b0, $sformatf("tbl%0d", t),
               tbl[t].res, tbl[t].cyc, tbl[t].ns);
    end

    // Empty program: finished the cycle after start, no strobe.
    run_prog(96'd0, 0, 1'b0, 1'b0, "len0", m_res, 2, 0);

    // start and prog_we held high while busy must neither restart nor overwrite mem[2].
    model_run(tbl[0].w, 3, mc);
    run_prog(tbl[0].w, 3, 1'b1, 1'b1, "busy_poke", 8'h33, 13, 3);
    model_run(tbl[0].w, 3, mc);
    run_prog(tbl[0].w, 3, 1'b0, 1'b0, "readback", 8'h33, 13, 3);

    for (int t = 0; t < 24; t++) begin
      rw = '0;
      for (int i = 0; i < 8; i++) rw[i*12 +: 12] = 12'($urandom_range(0, 4095));
      rn = $urandom_range(0, 8);
      model_run(rw, rn, mc);
      run_prog(rw, rn, 1'b1, 1'b0, $sformatf("rand%0d", t), m_res, mc, rn);
    end

    // Reset during the RUN phase of the XOR, then rerun from the retained program.
    prog_write(tbl[0].w);
    @(negedge clk);
    start = 1'b1; len = 4'd3;
    nseen = 0;
    for (int k = 0; k < 100 && nseen < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (s) nseen++;
    end
    chk("midreset.issued", nseen, 3);
    repeat (2) @(negedge clk);
    chk("midreset.pc_before", 32'(pc), 2);
    chk("midreset.busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.busy", 32'(busy), 0);
    chk("midreset.s", 32'(s), 0);
    chk("midreset.pc", 32'(pc), 0);
    chk("midreset.result", 32'(result), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_res = 8'h00;
    model_run(tbl[0].w, 3, mc);
    run_prog(tbl[0].w, 3, 1'b0, 1'b0, "after_reset", 8'h33, 13, 3);

`ifdef ISSUER_TIMEOUT_EN
    begin
      int c0, cf;
      bit seen;
      prog_write(p3(12'h10F, 12'h000, 12'h000));
      force_done1 = 1'b1;
      @(negedge clk);
      start = 1'b1; len = 4'd1; c0 = cyc;
      seen = 1'b0; cf = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (finished) begin seen = 1'b1; cf = cyc; end
      end
      // ISSUE is cycle 1 after start, ACK entered at cycle 2.
      chk("timeout.finished_seen", 32'(seen), 1);
      chk("timeout.cycles_from_ack", cf - c0 - 2, 16);
      chk("timeout.error", 32'(error), 1);
      force_done1 = 1'b0;
      m_r[1] = 8'h0F;
      exp_err = 1'b1;
      repeat (2) @(negedge clk);
      model_run(tbl[0].w, 3, mc);
      run_prog(tbl[0].w, 3, 1'b1, 1'b0, "after_timeout", 8'h33, 13, 3);
      reset = 1'b1;
      @(negedge clk);
      chk("timeout.error_cleared", 32'(error), 0);
      reset = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
